// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron bank with an output spike queue.
// Takes one weighted spike event per cycle, integrates it into the target
// neuron's membrane potential and fires on threshold crossing. A global
// leak tick decays all potentials and counts down refractory periods.
// Optional macro NEURON_INHIBIT_EN: treat in_weight as two's complement and
// clamp the integrated potential to [0, 2^POT_WIDTH-1].
module lif_neuron_array #(
    parameter int unsigned NUM_NEURONS  = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned POT_WIDTH    = 12,
    parameter int unsigned THRESHOLD    = 64,
    parameter int unsigned LEAK_SHIFT   = 3,
    parameter int unsigned REFRAC_TICKS = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic                    leak_tick,
    output logic                    spike_out_valid,
    output logic [ADDR_WIDTH-1:0]   spike_out_addr,
    input  logic                    spike_out_ready,
    output logic                    overflow,
    output logic [7:0]              dropped_count
);

    localparam int unsigned REF_W = 4;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = POT_WIDTH + 2;
    localparam logic [POT_WIDTH-1:0] POT_MAX = '1;

    logic [NUM_NEURONS-1:0][POT_WIDTH-1:0]  pot_q, pot_d;
    logic [NUM_NEURONS-1:0][REF_W-1:0]      ref_q, ref_d;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]  mem_q, mem_d;
    logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic                                   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]                  head_q, head_d;
    logic                                   overflow_q, overflow_d;
    logic [7:0]                             dropped_q, dropped_d;

    logic                  addr_ok;
    logic                  tgt_refrac;
    logic [POT_WIDTH-1:0]  vbase;
    logic [SUM_W-1:0]      vsum_w;
    logic [POT_WIDTH-1:0]  vsum;
    logic                  accept;
    logic                  fire;
    logic                  drop;
    logic                  pop;
    logic                  full;
    logic                  push_ok;

    // Next-state: leak, integrate/fire, spike queue and status counters
    always_comb begin
        pot_d      = pot_q;
        ref_d      = ref_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        tgt_refrac = 1'b0;
        vbase      = '0;
        vsum_w     = '0;
        vsum       = '0;

        if (leak_tick) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                pot_d[i] = pot_q[i] - (pot_q[i] >> LEAK_SHIFT);
                if (ref_q[i] != '0) begin
                    ref_d[i] = ref_q[i] - REF_W'(1);
                end
            end
        end

        // Refractory state is taken from before this cycle's decrement;
        // the base potential already includes this cycle's leak.
        addr_ok = {1'b0, in_addr} < (ADDR_WIDTH + 1)'(NUM_NEURONS);
        if (addr_ok) begin
            tgt_refrac = ref_q[in_addr] != '0;
            vbase      = pot_d[in_addr];
        end

`ifdef NEURON_INHIBIT_EN
        vsum_w = $signed({2'b00, vbase}) + SUM_W'($signed(in_weight));
`else
        vsum_w = {2'b00, vbase} + SUM_W'(in_weight);
`endif
        if (vsum_w[SUM_W-1]) begin
            vsum = '0;
        end else if (vsum_w[POT_WIDTH]) begin
            vsum = POT_MAX;
        end else begin
            vsum = vsum_w[POT_WIDTH-1:0];
        end

        accept = in_valid && addr_ok && !tgt_refrac;
        drop   = in_valid && !(addr_ok && !tgt_refrac);
        fire   = accept && (vsum >= POT_WIDTH'(THRESHOLD));

        if (accept) begin
            if (fire) begin
                pot_d[in_addr] = '0;
                ref_d[in_addr] = REF_W'(REFRAC_TICKS);
            end else begin
                pot_d[in_addr] = vsum;
            end
        end

        if (drop && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end

        // A pop frees the slot the same-cycle push needs when full
        pop     = valid_q && spike_out_ready;
        full    = count_q == CNT_W'(FIFO_DEPTH);
        push_ok = fire && (!full || pop);
        if (fire && full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = in_addr;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        valid_d = count_d != '0;
        if (valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pot_q      <= '0;
            ref_q      <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            pot_q      <= pot_d;
            ref_q      <= ref_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    assign spike_out_valid = valid_q;
    assign spike_out_addr  = head_q;
    assign overflow        = overflow_q;
    assign dropped_count   = dropped_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (default build).
module tb_lif_neuron_array;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_addr;
    logic [7:0] in_weight;
    logic       leak_tick;
    logic       spike_out_valid;
    logic [3:0] spike_out_addr;
    logic       spike_out_ready;
    logic       overflow;
    logic [7:0] dropped_count;

    int checks;
    int errors;

    lif_neuron_array dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_addr         (in_addr),
        .in_weight       (in_weight),
        .leak_tick       (leak_tick),
        .spike_out_valid (spike_out_valid),
        .spike_out_addr  (spike_out_addr),
        .spike_out_ready (spike_out_ready),
        .overflow        (overflow),
        .dropped_count   (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_addr   = 4'd0;
        in_weight = 8'd0;
        leak_tick = 1'b0;
    endtask

    task automatic event_cycle(input logic [3:0] a, input logic [7:0] w);
        in_valid  = 1'b1;
        in_addr   = a;
        in_weight = w;
        step();
        idle();
    endtask

    task automatic leak_cycle();
        leak_tick = 1'b1;
        step();
        leak_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (spike_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", spike_out_valid);
        end
        checks++;
        if (spike_out_addr !== 4'd0) begin
            errors++; $display("FAIL reset_addr: got %0d want 0", spike_out_addr);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %0b want 0", overflow);
        end
        checks++;
        if (dropped_count !== 8'd0) begin
            errors++; $display("FAIL reset_dropped: got %0d want 0", dropped_count);
        end
    endtask

    task automatic test_integrate_fire();
        logic [11:0] exp_pot [3];
        exp_pot[0] = 12'd20;
        exp_pot[1] = 12'd40;
        exp_pot[2] = 12'd60;
        for (int i = 0; i < 3; i++) begin
            event_cycle(4'd3, 8'd20);
            checks++;
            if (dut.pot_q[3] !== exp_pot[i] || spike_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL integrate_v3_%0d: got V=%0d valid=%0b want V=%0d valid=0",
                         i, dut.pot_q[3], spike_out_valid, exp_pot[i]);
            end
        end
        event_cycle(4'd3, 8'd20);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd3 || dut.pot_q[3] !== 12'd0) begin
            errors++;
            $display("FAIL fire_v3: got valid=%0b addr=%0d V=%0d want 1/3/0",
                     spike_out_valid, spike_out_addr, dut.pot_q[3]);
        end
        spike_out_ready = 1'b1;
        step();
        spike_out_ready = 1'b0;
        checks++;
        if (spike_out_valid !== 1'b0 || spike_out_addr !== 4'd3) begin
            errors++;
            $display("FAIL pop_hold_addr: got valid=%0b addr=%0d want 0/3",
                     spike_out_valid, spike_out_addr);
        end
    endtask

    task automatic test_refractory();
        event_cycle(4'd3, 8'd100);
        checks++;
        if (spike_out_valid !== 1'b0 || dropped_count !== 8'd1 || dut.pot_q[3] !== 12'd0) begin
            errors++;
            $display("FAIL refrac_drop1: got valid=%0b dropped=%0d V=%0d want 0/1/0",
                     spike_out_valid, dropped_count, dut.pot_q[3]);
        end
        for (int i = 0; i < 3; i++) leak_cycle();
        event_cycle(4'd3, 8'd100);
        checks++;
        if (spike_out_valid !== 1'b0 || dropped_count !== 8'd2) begin
            errors++;
            $display("FAIL refrac_drop2: got valid=%0b dropped=%0d want 0/2",
                     spike_out_valid, dropped_count);
        end
        leak_cycle();
        event_cycle(4'd3, 8'd70);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd3 || dropped_count !== 8'd2) begin
            errors++;
            $display("FAIL refrac_refire: got valid=%0b addr=%0d dropped=%0d want 1/3/2",
                     spike_out_valid, spike_out_addr, dropped_count);
        end
        spike_out_ready = 1'b1;
        step();
        spike_out_ready = 1'b0;
    endtask

    task automatic test_leak();
        event_cycle(4'd5, 8'd40);
        checks++;
        if (dut.pot_q[5] !== 12'd40) begin
            errors++; $display("FAIL leak_set_v5: got %0d want 40", dut.pot_q[5]);
        end
        leak_cycle();
        checks++;
        if (dut.pot_q[5] !== 12'd35) begin
            errors++; $display("FAIL leak_v5: got %0d want 35", dut.pot_q[5]);
        end
        leak_tick = 1'b1;
        event_cycle(4'd5, 8'd10);
        checks++;
        if (dut.pot_q[5] !== 12'd41) begin
            errors++; $display("FAIL leak_integrate_v5: got %0d want 41", dut.pot_q[5]);
        end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'd9;
        exp_seq[1] = 4'd10;
        exp_seq[2] = 4'd11;
        exp_seq[3] = 4'd6;
        spike_out_ready = 1'b0;
        for (int n = 8; n < 12; n++) event_cycle(4'(n), 8'd64);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_head: got valid=%0b addr=%0d ovf=%0b want 1/8/0",
                     spike_out_valid, spike_out_addr, overflow);
        end
        spike_out_ready = 1'b1;
        event_cycle(4'd6, 8'd64);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL pushpop_overflow: got %0b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (spike_out_valid !== 1'b1 || spike_out_addr !== exp_seq[i]) begin
                errors++;
                $display("FAIL pushpop_order_%0d: got valid=%0b addr=%0d want 1/%0d",
                         i, spike_out_valid, spike_out_addr, exp_seq[i]);
            end
            step();
        end
        spike_out_ready = 1'b0;
        checks++;
        if (spike_out_valid !== 1'b0) begin
            errors++; $display("FAIL pushpop_empty: got %0b want 0", spike_out_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) leak_cycle();
        spike_out_ready = 1'b0;
        for (int n = 0; n < 4; n++) event_cycle(4'(n), 8'd64);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got valid=%0b addr=%0d ovf=%0b want 1/0/0",
                     spike_out_valid, spike_out_addr, overflow);
        end
        event_cycle(4'd4, 8'd64);
        checks++;
        if (overflow !== 1'b1 || dut.pot_q[4] !== 12'd0 || dropped_count !== 8'd2) begin
            errors++;
            $display("FAIL bp_overflow: got ovf=%0b V4=%0d dropped=%0d want 1/0/2",
                     overflow, dut.pot_q[4], dropped_count);
        end
        event_cycle(4'd4, 8'd10);
        checks++;
        if (dropped_count !== 8'd3 || dut.pot_q[4] !== 12'd0) begin
            errors++;
            $display("FAIL bp_lost_refrac: got dropped=%0d V4=%0d want 3/0",
                     dropped_count, dut.pot_q[4]);
        end
        spike_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'(i)) begin
                errors++;
                $display("FAIL bp_order_%0d: got valid=%0b addr=%0d want 1/%0d",
                         i, spike_out_valid, spike_out_addr, i);
            end
            step();
        end
        spike_out_ready = 1'b0;
        checks++;
        if (spike_out_valid !== 1'b0 || spike_out_addr !== 4'd3 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained: got valid=%0b addr=%0d ovf=%0b want 0/3/1",
                     spike_out_valid, spike_out_addr, overflow);
        end
    endtask

    task automatic test_reset_mid();
        spike_out_ready = 1'b0;
        event_cycle(4'd12, 8'd64);
        event_cycle(4'd13, 8'd64);
        event_cycle(4'd7, 8'd50);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd12 || dut.pot_q[7] !== 12'd50) begin
            errors++;
            $display("FAIL mid_setup: got valid=%0b addr=%0d V7=%0d want 1/12/50",
                     spike_out_valid, spike_out_addr, dut.pot_q[7]);
        end
        rst = 1'b1;
        event_cycle(4'd7, 8'd20);
        rst = 1'b0;
        checks++;
        if (spike_out_valid !== 1'b0 || spike_out_addr !== 4'd0 || overflow !== 1'b0 ||
            dropped_count !== 8'd0 || dut.pot_q[7] !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b addr=%0d ovf=%0b dropped=%0d V7=%0d want 0/0/0/0/0",
                     spike_out_valid, spike_out_addr, overflow, dropped_count, dut.pot_q[7]);
        end
        event_cycle(4'd7, 8'd63);
        checks++;
        if (spike_out_valid !== 1'b0 || dut.pot_q[7] !== 12'd63) begin
            errors++;
            $display("FAIL mid_nofire: got valid=%0b V7=%0d want 0/63",
                     spike_out_valid, dut.pot_q[7]);
        end
        event_cycle(4'd3, 8'd64);
        checks++;
        if (spike_out_valid !== 1'b1 || spike_out_addr !== 4'd3 || dropped_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_refrac_cleared: got valid=%0b addr=%0d dropped=%0d want 1/3/0",
                     spike_out_valid, spike_out_addr, dropped_count);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        spike_out_ready = 1'b0;
        idle();
        test_reset();
        test_integrate_fire();
        test_refractory();
        test_leak();
        test_push_pop_full();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
